// File: rtl/ysyx_22040088_memarb.sv
// Shares one memory port between IFU and LSU with at most one transaction outstanding.
// Define YSYX_22040088_MEMARB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module ysyx_22040088_memarb #(
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [63:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_wen,
  input  logic [3:0]        ls_mask,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [63:0]       ls_wdata,
  output logic              ls_ready,
  output logic              ls_rvalid,
  output logic [63:0]       ls_rdata,
  output logic              ls_err,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(7);

  logic [1:0]        state, state_d;
  logic              own_ls, own_ls_d;
  logic              bad, bad_d;
  logic              if_ready_d, if_rvalid_d, ls_ready_d, ls_rvalid_d, ls_err_d;
  logic              mem_req_d, mem_wen_d;
  logic [DATA_W-1:0] if_rdata_d, ls_rdata_d, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [STRB_W-1:0] mem_wstrb_d;

  logic              pick_ls_c, pick_if_c, illegal_c;
  logic [2:0]        off_c;
  logic [STRB_W-1:0] strb_c;

  // Size decode: byte-lane strobe and alignment check for the LSU request
  always_comb begin
    off_c     = ls_addr[2:0];
    strb_c    = 8'h00;
    illegal_c = 1'b1;
    case (ls_mask)
      4'b0001: begin strb_c = 8'hFF; illegal_c = (off_c != 3'd0);      end
      4'b0010: begin strb_c = 8'h0F; illegal_c = (off_c[1:0] != 2'd0); end
      4'b0100: begin strb_c = 8'h03; illegal_c = off_c[0];             end
      4'b1000: begin strb_c = 8'h01; illegal_c = 1'b0;                 end
      default: ;
    endcase
    strb_c = strb_c << off_c;
  end

`ifdef YSYX_22040088_MEMARB_RR_EN
  logic last_ifu, last_ifu_d;
  assign pick_ls_c = ls_req && (!if_req || last_ifu);
`else
  assign pick_ls_c = ls_req;
`endif
  assign pick_if_c = if_req && !pick_ls_c;

  // Next-state and registered-output values
  always_comb begin
    state_d     = state;
    own_ls_d    = own_ls;
    bad_d       = bad;
    if_ready_d  = 1'b0;
    ls_ready_d  = 1'b0;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    ls_err_d    = 1'b0;
    if_rdata_d  = if_rdata;
    ls_rdata_d  = ls_rdata;
    mem_req_d   = mem_req;
    mem_wen_d   = mem_wen;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wstrb_d = mem_wstrb;
`ifdef YSYX_22040088_MEMARB_RR_EN
    last_ifu_d  = last_ifu;
`endif
    case (state)
      S_IDLE: begin
        // A ready pulse marks the accept cycle; the request is launched one cycle later
        if (if_ready || ls_ready) begin
          if (bad) begin
            state_d     = S_ERR;
            ls_rvalid_d = 1'b1;
            ls_err_d    = 1'b1;
            ls_rdata_d  = '0;
          end else begin
            state_d   = S_REQ;
            mem_req_d = 1'b1;
          end
        end else if (pick_ls_c) begin
          ls_ready_d  = 1'b1;
          own_ls_d    = 1'b1;
          bad_d       = illegal_c;
          mem_addr_d  = ls_addr & WORD_MASK;
          mem_wen_d   = ls_wen;
          mem_wstrb_d = ls_wen ? strb_c : 8'h00;
          mem_wdata_d = ls_wdata << {off_c, 3'b000};
`ifdef YSYX_22040088_MEMARB_RR_EN
          last_ifu_d  = 1'b0;
`endif
        end else if (pick_if_c) begin
          if_ready_d  = 1'b1;
          own_ls_d    = 1'b0;
          bad_d       = 1'b0;
          mem_addr_d  = if_addr & WORD_MASK;
          mem_wen_d   = 1'b0;
          mem_wstrb_d = 8'h00;
          mem_wdata_d = '0;
`ifdef YSYX_22040088_MEMARB_RR_EN
          last_ifu_d  = 1'b1;
`endif
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d   = S_WAIT;
          mem_req_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
          if (own_ls) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      own_ls    <= 1'b0;
      bad       <= 1'b0;
      if_ready  <= 1'b0;
      ls_ready  <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_err    <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
`ifdef YSYX_22040088_MEMARB_RR_EN
      last_ifu  <= 1'b1;
`endif
    end else begin
      state     <= state_d;
      own_ls    <= own_ls_d;
      bad       <= bad_d;
      if_ready  <= if_ready_d;
      ls_ready  <= ls_ready_d;
      if_rvalid <= if_rvalid_d;
      ls_rvalid <= ls_rvalid_d;
      ls_err    <= ls_err_d;
      if_rdata  <= if_rdata_d;
      ls_rdata  <= ls_rdata_d;
      mem_req   <= mem_req_d;
      mem_wen   <= mem_wen_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wstrb <= mem_wstrb_d;
`ifdef YSYX_22040088_MEMARB_RR_EN
      last_ifu  <= last_ifu_d;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_22040088_memarb.sv
// Self-checking bench for ysyx_22040088_memarb: directed and randomized transactions
// against a byte-level reference model, with a behavioural memory responder.
module tb_ysyx_22040088_memarb;
  localparam int unsigned ADDR_W = 64;

  logic              clk, rst_n;
  logic              if_req, if_ready, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [63:0]       if_rdata;
  logic              ls_req, ls_wen, ls_ready, ls_rvalid, ls_err;
  logic [3:0]        ls_mask;
  logic [ADDR_W-1:0] ls_addr;
  logic [63:0]       ls_wdata, ls_rdata;
  logic              mem_req, mem_wen, mem_gnt, mem_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata, mem_rdata;
  logic [7:0]        mem_wstrb;

  int npass = 0;
  int ntotal = 0;

  bit          resp_en;
  int          gdly;
  logic [63:0] resp_data;
  int          rs, rcnt;
  bit          snap_seen, stable_bad;
  logic [63:0] snap_addr, snap_wdata;
  logic [7:0]  snap_wstrb;
  logic        snap_wen;

  ysyx_22040088_memarb #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_wen(ls_wen), .ls_mask(ls_mask), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Memory responder: grant after gdly cycles, return resp_data the cycle after grant
  always @(negedge clk) begin
    if (!resp_en || !rst_n) rs = 0;
    else begin
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      case (rs)
        0: if (mem_req) begin
          snap_seen = 1; snap_addr = mem_addr; snap_wdata = mem_wdata;
          snap_wstrb = mem_wstrb; snap_wen = mem_wen; rcnt = 0;
          if (gdly == 0) begin mem_gnt = 1'b1; rs = 2; end else rs = 1;
        end
        1: begin
          if (!mem_req || mem_addr !== snap_addr || mem_wdata !== snap_wdata ||
              mem_wstrb !== snap_wstrb || mem_wen !== snap_wen || if_ready || ls_ready)
            stable_bad = 1;
          rcnt++;
          if (rcnt >= gdly) begin mem_gnt = 1'b1; rs = 2; end
        end
        default: begin mem_rvalid = 1'b1; mem_rdata = resp_data; rs = 0; end
      endcase
    end
  end

  function automatic int size_of(input logic [3:0] m);
    case (m)
      4'b0001: return 8;
      4'b0010: return 4;
      4'b0100: return 2;
      4'b1000: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [3:0] m, input logic [63:0] a);
    int s;
    s = size_of(m);
    return (s != 0) && ((int'(a[2:0]) % s) == 0);
  endfunction

  function automatic logic [7:0] exp_strb(input bit wen, input logic [3:0] m, input logic [63:0] a);
    if (!wen) return 8'h00;
    return 8'(((1 << size_of(m)) - 1) << int'(a[2:0]));
  endfunction

  // Byte i of the memory word carries byte (i - offset) of the right-aligned store data
  function automatic logic [63:0] exp_wdata(input logic [63:0] d, input logic [63:0] a);
    logic [63:0] r;
    int o;
    r = '0;
    o = int'(a[2:0]);
    for (int i = 0; i < 8; i++) if (i >= o) r[8*i +: 8] = d[8*(i-o) +: 8];
    return r;
  endfunction

  // Drives one request, waits for accept, then observes until the owner's response
  task automatic issue(input bit is_ls, input logic [63:0] addr, input bit wen, input logic [3:0] mask,
                       input logic [63:0] wdata, output bit acc, output int req_lat, output int rv_lat,
                       output logic [63:0] rdata, output logic err, output bit stray);
    acc = 0; req_lat = -1; rv_lat = -1; rdata = '0; err = 1'b0; stray = 0;
    snap_seen = 0;
    @(negedge clk);
    if (is_ls) begin
      ls_req = 1'b1; ls_addr = addr; ls_wen = wen; ls_mask = mask; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge clk);
      acc = is_ls ? ls_ready : if_ready;
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    if (acc) begin
      for (int c = 1; c <= 40 && rv_lat < 0; c++) begin
        @(negedge clk);
        if (mem_req && req_lat < 0) req_lat = c;
        if (if_ready || ls_ready) stray = 1;
        if (is_ls ? if_rvalid : ls_rvalid) stray = 1;
        if (is_ls ? ls_rvalid : if_rvalid) begin
          rv_lat = c; rdata = is_ls ? ls_rdata : if_rdata; err = ls_err;
        end
      end
      if (rv_lat >= 0) begin
        @(negedge clk);
        if ((is_ls ? ls_rvalid : if_rvalid) || ls_err) stray = 1;
        if ((is_ls ? ls_rdata : if_rdata) !== rdata) stray = 1;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    ntotal++;
    if ({if_ready, if_rvalid, ls_ready, ls_rvalid, ls_err, mem_req, mem_wen} !== 7'b0)
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {if_ready, if_rvalid, ls_ready, ls_rvalid, ls_err, mem_req, mem_wen});
    else npass++;
    ntotal++;
    if ({mem_addr, mem_wdata, mem_wstrb, if_rdata, ls_rdata} !== '0)
      $display("FAIL reset_data: addr %h wdata %h strb %h ifr %h lsr %h expected all 0",
               mem_addr, mem_wdata, mem_wstrb, if_rdata, ls_rdata);
    else npass++;
    rst_n = 1'b1;
    // Stray handshakes while idle must be ignored
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    ntotal++;
    if ({if_rvalid, ls_rvalid, mem_req} !== 3'b0 || if_rdata !== 64'h0 || ls_rdata !== 64'h0)
      $display("FAIL idle_ignore: rv %b%b req %b ifr %h lsr %h expected 0", if_rvalid, ls_rvalid,
               mem_req, if_rdata, ls_rdata);
    else npass++;
    resp_en = 1;
  endtask

  task automatic test_ifu_fetch;
    bit acc, stray; int rl, vl; logic [63:0] rd; logic er;
    gdly = 0; resp_data = 64'h1122334455667788;
    issue(0, 64'h8000_0004, 0, 4'b0000, '0, acc, rl, vl, rd, er, stray);
    ntotal++;
    if (!acc || rl !== 1 || vl !== 3)
      $display("FAIL ifu_latency: acc %0d mem_req %0d rvalid %0d expected 1 1 3", acc, rl, vl);
    else npass++;
    ntotal++;
    if (rd !== 64'h1122334455667788 || er !== 1'b0 || stray)
      $display("FAIL ifu_data: rdata %h err %b stray %0d expected 1122334455667788 0 0", rd, er, stray);
    else npass++;
    ntotal++;
    if (!snap_seen || snap_addr !== 64'h8000_0000 || snap_wstrb !== 8'h00 || snap_wen !== 1'b0 ||
        snap_wdata !== 64'h0)
      $display("FAIL ifu_mem: addr %h strb %h wen %b wdata %h expected 80000000 00 0 0",
               snap_addr, snap_wstrb, snap_wen, snap_wdata);
    else npass++;
  endtask

  task automatic test_misaligned;
    bit acc, stray; int rl, vl; logic [63:0] rd; logic er;
    logic [3:0] masks [2];
    masks[0] = 4'b0010; masks[1] = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      issue(1, 64'h8000_0006, 1, masks[k], 64'h1234_5678, acc, rl, vl, rd, er, stray);
      ntotal++;
      if (!acc || rl !== -1 || vl !== 1)
        $display("FAIL err_timing mask %b: acc %0d mem_req %0d rvalid %0d expected 1 -1 1",
                 masks[k], acc, rl, vl);
      else npass++;
      ntotal++;
      if (er !== 1'b1 || rd !== 64'h0 || stray)
        $display("FAIL err_resp mask %b: err %b rdata %h stray %0d expected 1 0 0",
                 masks[k], er, rd, stray);
      else npass++;
    end
  endtask

  task automatic test_store_half;
    bit acc, stray; int rl, vl; logic [63:0] rd; logic er;
    gdly = 1; resp_data = 64'h0;
    issue(1, 64'h8000_0006, 1, 4'b0100, 64'hBEEF, acc, rl, vl, rd, er, stray);
    ntotal++;
    if (!snap_seen || snap_wstrb !== 8'b1100_0000 || snap_wdata !== 64'hBEEF_0000_0000_0000 ||
        snap_wen !== 1'b1 || snap_addr !== 64'h8000_0000)
      $display("FAIL sh_mem: strb %b wdata %h wen %b addr %h expected 11000000 beef000000000000 1 80000000",
               snap_wstrb, snap_wdata, snap_wen, snap_addr);
    else npass++;
    ntotal++;
    if (vl !== 4 || er !== 1'b0 || stray)
      $display("FAIL sh_resp: rvalid %0d err %b stray %0d expected 4 0 0", vl, er, stray);
    else npass++;
  endtask

  task automatic test_gnt_delay;
    bit acc, stray; int rl, vl; logic [63:0] rd; logic er;
    gdly = 5; resp_data = 64'hCAFE_F00D_1234_5678; stable_bad = 0;
    issue(1, 64'h8000_0010, 0, 4'b0001, 64'h0, acc, rl, vl, rd, er, stray);
    ntotal++;
    if (stable_bad || stray)
      $display("FAIL gnt_stall: unstable %0d stray %0d expected 0 0", stable_bad, stray);
    else npass++;
    ntotal++;
    if (vl !== 8 || rd !== 64'hCAFE_F00D_1234_5678)
      $display("FAIL gnt_resp: rvalid %0d rdata %h expected 8 cafef00d12345678", vl, rd);
    else npass++;
  endtask

  task automatic test_random;
    bit acc, stray, is_ls, wen, ok; int rl, vl, d; logic [63:0] rd, a, wd, ea; logic er;
    logic [3:0] m;
    for (int t = 0; t < 40; t++) begin
      is_ls = ($urandom_range(0, 2) != 0);
      a = {$urandom, $urandom};
      wen = 1'($urandom_range(0, 1));
      m = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      wd = {$urandom, $urandom};
      d = $urandom_range(0, 3);
      gdly = d; resp_data = {$urandom, $urandom}; stable_bad = 0;
      issue(is_ls, a, wen, m, wd, acc, rl, vl, rd, er, stray);
      ok = !is_ls || is_legal(m, a);
      ea = a - 64'(a % 8);
      ntotal++;
      if (!acc || stray || stable_bad)
        $display("FAIL rand%0d_handshake: acc %0d stray %0d unstable %0d expected 1 0 0",
                 t, acc, stray, stable_bad);
      else npass++;
      ntotal++;
      if (ok && (rl !== 1 || vl !== 3 + d || rd !== resp_data || er !== 1'b0))
        $display("FAIL rand%0d_resp: req %0d rv %0d rdata %h err %b expected 1 %0d %h 0",
                 t, rl, vl, rd, er, 3 + d, resp_data);
      else if (!ok && (rl !== -1 || vl !== 1 || rd !== 64'h0 || er !== 1'b1))
        $display("FAIL rand%0d_err: req %0d rv %0d rdata %h err %b expected -1 1 0 1",
                 t, rl, vl, rd, er);
      else npass++;
      if (ok) begin
        ntotal++;
        if (!snap_seen || snap_addr !== ea ||
            snap_wstrb !== (is_ls ? exp_strb(wen, m, a) : 8'h00) ||
            snap_wdata !== (is_ls ? exp_wdata(wd, a) : 64'h0) ||
            snap_wen !== (is_ls ? wen : 1'b0))
          $display("FAIL rand%0d_mem: addr %h strb %h wdata %h wen %b expected %h %h %h %b", t,
                   snap_addr, snap_wstrb, snap_wdata, snap_wen, ea,
                   is_ls ? exp_strb(wen, m, a) : 8'h00, is_ls ? exp_wdata(wd, a) : 64'h0,
                   is_ls ? wen : 1'b0);
        else npass++;
      end
    end
  endtask

  task automatic test_arbitration;
    bit last_ifu, seen_if, seen_ls, exp_ls;
    last_ifu = 1; gdly = 0; resp_data = 64'h55;
    @(negedge clk);
    if_req = 1'b1; if_addr = 64'h8000_0200;
    ls_req = 1'b1; ls_addr = 64'h8000_0300; ls_wen = 1'b0; ls_mask = 4'b0001; ls_wdata = '0;
    for (int t = 0; t < 4; t++) begin
      seen_if = 0; seen_ls = 0;
      for (int i = 0; i < 12 && !seen_if && !seen_ls; i++) begin
        @(negedge clk);
        seen_if = if_ready; seen_ls = ls_ready;
      end
`ifdef YSYX_22040088_MEMARB_RR_EN
      exp_ls = last_ifu;
`else
      exp_ls = 1;
`endif
      last_ifu = !exp_ls;
      ntotal++;
      if (seen_ls !== exp_ls || seen_if !== !exp_ls)
        $display("FAIL arb%0d: ls_ready %0d if_ready %0d expected %0d %0d",
                 t, seen_ls, seen_if, exp_ls, !exp_ls);
      else npass++;
    end
    if_req = 1'b0; ls_req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_midtxn;
    bit acc, got, seen_rv, seen_req;
    acc = 0; got = 0; seen_rv = 0; seen_req = 0;
    resp_en = 0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 64'h8000_0100;
    for (int i = 0; i < 10 && !acc; i++) begin @(negedge clk); acc = if_ready; end
    if_req = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = mem_req; end
    ntotal++;
    if (!acc || !got) $display("FAIL midrst_setup: acc %0d mem_req %0d expected 1 1", acc, got);
    else npass++;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hFEED_FACE_0000_0001;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (if_rvalid || ls_rvalid) seen_rv = 1;
      if (mem_req) seen_req = 1;
      @(negedge clk);
    end
    ntotal++;
    if (seen_rv || seen_req || if_rdata !== 64'h0)
      $display("FAIL midrst: rvalid %0d mem_req %0d if_rdata %h expected 0 0 0", seen_rv, seen_req, if_rdata);
    else npass++;
    resp_en = 1;
  endtask

  task automatic test_back_to_back;
    bit acc, stray; int rl, vl; logic [63:0] rd; logic er;
    gdly = 0; resp_data = 64'h0102_0304_0506_0708;
    issue(1, 64'h8000_0021, 1, 4'b1000, 64'hA5, acc, rl, vl, rd, er, stray);
    ntotal++;
    if (!acc || vl !== 3 || stray || snap_wstrb !== 8'h02 || snap_wdata !== 64'hA500)
      $display("FAIL after_reset_sb: acc %0d rv %0d stray %0d strb %h wdata %h expected 1 3 0 02 a500",
               acc, vl, stray, snap_wstrb, snap_wdata);
    else npass++;
  endtask

  initial begin
    rst_n = 1'b0; resp_en = 0; gdly = 0; resp_data = '0; rs = 0; rcnt = 0;
    snap_seen = 0; stable_bad = 0;
    snap_addr = '0; snap_wdata = '0; snap_wstrb = '0; snap_wen = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_wen = 1'b0; ls_mask = 4'b0; ls_addr = '0; ls_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    test_reset();
    test_ifu_fetch();
    test_misaligned();
    test_store_half();
    test_gnt_delay();
    test_arbitration();
    test_random();
    test_reset_midtxn();
    test_back_to_back();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/ysyx_22040088_memarb.md
YSYX_22040088_MEMARB -- requirements
Module: ysyx_22040088_memarb

Interface
REQ-001 Parameter: ADDR_W, 64, width of every address port.
REQ-002 Port: clk  in  1  system clock; all state changes on rising edge.
REQ-003 Port: rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-004 Ports IFU side: if_req in 1 fetch request; if_addr in ADDR_W; if_ready out 1 accept pulse; if_rvalid out 1 response pulse; if_rdata out 64.
REQ-005 Ports LSU side: ls_req in 1; ls_wen in 1 store when 1; ls_mask in 4 one-hot size (0001=8B, 0010=4B, 0100=2B, 1000=1B); ls_addr in ADDR_W; ls_wdata in 64 right-aligned data; ls_ready out 1; ls_rvalid out 1; ls_rdata out 64; ls_err out 1.
REQ-006 Ports memory side: mem_req out 1; mem_wen out 1; mem_addr out ADDR_W; mem_wdata out 64; mem_wstrb out 8; mem_gnt in 1; mem_rvalid in 1; mem_rdata in 64.

Function
REQ-007 Block SHALL share one memory port between IFU and LSU, at most one transaction outstanding.
REQ-008 FSM states SHALL be IDLE, REQ, WAIT, ERR.
REQ-009 IDLE: if any requester selected, SHALL pulse that requester's ready for exactly that cycle and latch its address, wen, mask, wdata.
REQ-010 Arbitration without macro: LSU wins when if_req and ls_req both high.
REQ-011 IDLE -> REQ on accepted valid request; IDLE -> ERR on accepted LSU request with illegal mask or misalignment.
REQ-012 Illegal: ls_mask not one-hot, or addr[2:0] not a multiple of the access size.
REQ-013 REQ: mem_req SHALL be 1 with stable mem_* outputs until mem_gnt=1; REQ -> WAIT on mem_gnt.
REQ-014 WAIT: mem_req=0; on mem_rvalid=1 SHALL register mem_rdata and go IDLE.
REQ-015 Owner's rvalid SHALL pulse one cycle, in the cycle after mem_rvalid, with rdata held until the next response; a new accept MAY occur in that same cycle.
REQ-016 Minimum latency: accept cycle N, mem_req N+1, gnt N+1, rvalid N+2, owner rvalid N+3.
REQ-017 mem_addr SHALL be latched address with bits [2:0] cleared.
REQ-018 mem_wstrb: LSU store = (2^size - 1) << addr[2:0], size in bytes from mask; loads and IFU = 8'h00; mem_wen = ls_wen for LSU, 0 for IFU.
REQ-019 mem_wdata SHALL be ls_wdata << (8*addr[2:0]); 0 for IFU.
REQ-020 Read data SHALL be returned unshifted; lane extraction belongs to the requester.
REQ-021 ERR: no memory access; ls_rvalid=1, ls_err=1, ls_rdata=0 for one cycle, then IDLE.
REQ-022 ls_err SHALL be 0 with every non-error response.
REQ-023 mem_rvalid or mem_gnt outside REQ/WAIT SHALL be ignored.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force IDLE and clear all registered outputs: ready/rvalid/err/mem_req/mem_wen 0, data/addr/strb 0.
REQ-025 Reset mid-transaction SHALL abandon it: no response pulse, a later mem_rvalid ignored.
REQ-026 Round-robin pointer (when compiled in) SHALL reset to "IFU served last".

Configuration
REQ-027 Macro YSYX_22040088_MEMARB_RR_EN: defined -> on simultaneous requests grant the requester not served last, pointer updated on every accept; undefined -> fixed LSU priority per REQ-010, no pointer register.

Verification
REQ-028 IFU fetch addr 0x8000_0004, gnt same cycle, rdata 0x1122334455667788 -> mem_addr 0x8000_0000, wstrb 00, if_rvalid at N+3 with that data.
REQ-029 LSU sw addr 0x8000_0006 mask 0010 -> no mem_req, ls_rvalid+ls_err one cycle after accept, ls_rdata 0.
REQ-030 LSU sh addr 0x8000_0006 wdata 0xBEEF -> wstrb 8'b1100_0000, wdata 0xBEEF000000000000, wen 1.
REQ-031 if_req and ls_req held high for 4 transactions -> without macro L,L,L,L; with macro L,I,L,I.
REQ-032 mem_gnt delayed 5 cycles -> mem_req and mem_* stable all 5 cycles, no ready pulses.
REQ-033 rst_n low during WAIT then mem_rvalid -> no if_rvalid/ls_rvalid, FSM IDLE, mem_req 0.
